triangle_coverage_pipe: RTL and testbench

//  Streaming triangle coverage tester: evaluates all three edge functions of one triangle at one pixel per accepted beat.

---
 rtl/triangle_coverage_pipe.sv | 189 ++++++++++++++++++
 tb/tb_triangle_coverage_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_coverage_pipe.sv
// triangle_coverage_pipe
//   Streaming triangle coverage test. Each accepted beat carries one pixel plus the three
//   vertices of a triangle; the block evaluates the three edge functions, classifies the pixel
//   as covered or not, and emits the raw edge weights for barycentric interpolation.
//   Latency from accept to outValid is 3 + MUL_STAGES cycles; one beat per cycle sustained.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   inValid / inReady           upstream handshake (inReady is combinational from outReady)
//   pixel_x, pixel_y            pixel coordinate, unsigned
//   V0_x .. V2_y                vertex coordinates, signed two's complement
//   cull_mode                   0: all w >= 0, 1: all w <= 0, 2/3: either sign
//   outValid / outReady         downstream handshake
//   isInside                    coverage result
//   w0, w1, w2                  signed edge values (edges V1->V2, V2->V0, V0->V1)
//   pixel_x_out, pixel_y_out    pixel of the result beat
module triangle_coverage_pipe #(
  parameter int unsigned COORD_W       = 11,
  parameter int unsigned MUL_STAGES    = 1,
  parameter bit          TIE_INCLUSIVE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  input  logic [COORD_W-1:0]   V0_x,
  input  logic [COORD_W-1:0]   V0_y,
  input  logic [COORD_W-1:0]   V1_x,
  input  logic [COORD_W-1:0]   V1_y,
  input  logic [COORD_W-1:0]   V2_x,
  input  logic [COORD_W-1:0]   V2_y,
  input  logic [1:0]           cull_mode,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 isInside,
  output logic [2*COORD_W+4:0] w0,
  output logic [2*COORD_W+4:0] w1,
  output logic [2*COORD_W+4:0] w2,
  output logic [COORD_W-1:0]   pixel_x_out,
  output logic [COORD_W-1:0]   pixel_y_out
);

  localparam int unsigned DW = COORD_W + 2;      // signed difference width
  localparam int unsigned PW = 2 * DW;           // product width
  localparam int unsigned EW = 2 * COORD_W + 5;  // edge value width
  localparam int unsigned SW = EW + 2;           // area sum width
  localparam int unsigned NS = 3 + MUL_STAGES;   // pipeline depth
  localparam int unsigned ES = MUL_STAGES + 1;   // edge subtraction stage index
  localparam int unsigned XW = 2 * COORD_W + 2;  // side band: {cull, px, py}

  if (MUL_STAGES != 1 && MUL_STAGES != 2) begin : gen_bad_mul_stages
    $error("MUL_STAGES must be 1 or 2");
  end

  logic [NS-1:0]        v_q;
  logic [NS-1:0]        ce;
  logic                 hole;
  logic signed [DW-1:0] vx [3];
  logic signed [DW-1:0] vy [3];
  logic signed [DW-1:0] pxe;
  logic signed [DW-1:0] pye;
  logic signed [DW-1:0] diff_c [12];
  logic signed [DW-1:0] diff_q [12];
  logic signed [PW-1:0] prod_c [6];
  logic signed [PW-1:0] prod_q [MUL_STAGES][6];
  logic signed [EW-1:0] edge_c [3];
  logic signed [EW-1:0] edge_q [3];
  logic signed [EW-1:0] w_q [3];
  logic signed [SW-1:0] sum_c;
  logic [XW-1:0]        side_q [NS];
  logic [1:0]           cull_e;
  logic                 pos_ok;
  logic                 neg_ok;
  logic                 inside_c;
  logic                 inside_q;

  // A stage may load when it is empty or anything downstream of it can move; this lets
  // bubbles collapse while the output is stalled.
  always_comb begin
    ce   = '0;
    hole = outReady;
    for (int k = NS - 1; k >= 0; k--) begin
      hole  = hole | ~v_q[k];
      ce[k] = hole;
    end
  end

  // Per edge i (A -> B): {P.x - A.x, B.y - A.y, P.y - A.y, B.x - A.x}.
  always_comb begin
    vx[0] = {{2{V0_x[COORD_W-1]}}, V0_x};
    vy[0] = {{2{V0_y[COORD_W-1]}}, V0_y};
    vx[1] = {{2{V1_x[COORD_W-1]}}, V1_x};
    vy[1] = {{2{V1_y[COORD_W-1]}}, V1_y};
    vx[2] = {{2{V2_x[COORD_W-1]}}, V2_x};
    vy[2] = {{2{V2_y[COORD_W-1]}}, V2_y};
    pxe   = {2'b00, pixel_x};
    pye   = {2'b00, pixel_y};
    for (int i = 0; i < 3; i++) begin
      diff_c[4*i]   = pxe - vx[(i+1)%3];
      diff_c[4*i+1] = vy[(i+2)%3] - vy[(i+1)%3];
      diff_c[4*i+2] = pye - vy[(i+1)%3];
      diff_c[4*i+3] = vx[(i+2)%3] - vx[(i+1)%3];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      prod_c[2*i]   = PW'(diff_q[4*i])   * PW'(diff_q[4*i+1]);
      prod_c[2*i+1] = PW'(diff_q[4*i+2]) * PW'(diff_q[4*i+3]);
      edge_c[i]     = EW'(prod_q[MUL_STAGES-1][2*i]) - EW'(prod_q[MUL_STAGES-1][2*i+1]);
    end
  end

  // Zero area sum means a degenerate triangle, which never covers anything.
  always_comb begin
    sum_c    = SW'(edge_q[0]) + SW'(edge_q[1]) + SW'(edge_q[2]);
    cull_e   = side_q[ES][XW-1 -: 2];
    pos_ok   = 1'b1;
    neg_ok   = 1'b1;
    inside_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (TIE_INCLUSIVE) begin
        pos_ok = pos_ok & ~edge_q[i][EW-1];
        neg_ok = neg_ok & (edge_q[i][EW-1] | ~|edge_q[i]);
      end else begin
        pos_ok = pos_ok & ~edge_q[i][EW-1] & |edge_q[i];
        neg_ok = neg_ok & edge_q[i][EW-1];
      end
    end
    if (sum_c != '0) begin
      unique case (cull_e)
        2'd0:    inside_c = pos_ok;
        2'd1:    inside_c = neg_ok;
        default: inside_c = pos_ok | neg_ok;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else begin
      if (ce[0]) v_q[0] <= inValid;
      for (int k = 1; k < NS; k++) begin
        if (ce[k]) v_q[k] <= v_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      diff_q   <= '{default: '0};
      prod_q   <= '{default: '{default: '0}};
      edge_q   <= '{default: '0};
      w_q      <= '{default: '0};
      side_q   <= '{default: '0};
      inside_q <= 1'b0;
    end else begin
      if (ce[0]) begin
        diff_q    <= diff_c;
        side_q[0] <= {cull_mode, pixel_x, pixel_y};
      end
      for (int k = 1; k < NS; k++) begin
        if (ce[k]) side_q[k] <= side_q[k-1];
      end
      if (ce[1]) prod_q[0] <= prod_c;
      for (int m = 1; m < MUL_STAGES; m++) begin
        if (ce[m+1]) prod_q[m] <= prod_q[m-1];
      end
      if (ce[ES]) edge_q <= edge_c;
      if (ce[NS-1]) begin
        w_q      <= edge_q;
        inside_q <= inside_c;
      end
    end
  end

  assign inReady     = ce[0];
  assign outValid    = v_q[NS-1];
  assign isInside    = inside_q;
  assign w0          = w_q[0];
  assign w1          = w_q[1];
  assign w2          = w_q[2];
  assign pixel_x_out = side_q[NS-1][XW-3 -: COORD_W];
  assign pixel_y_out = side_q[NS-1][COORD_W-1:0];

endmodule

// File: tb/tb_triangle_coverage_pipe.sv
// Bench for triangle_coverage_pipe. Two instances run in lockstep on the same beats:
// dut_a (MUL_STAGES=1, inclusive ties) and dut_b (MUL_STAGES=2, strict ties). A beat is
// offered to each only while the other is also ready, so both accept identical streams.
// The driver pushes expected results into per-instance queues; monitors pop and compare.
module tb_triangle_coverage_pipe;

  localparam int CW = 11;
  localparam int EW = 2 * CW + 5;
  localparam int LA = 4;
  localparam int LB = 5;

  typedef struct packed {
    logic [CW-1:0] px, py, v0x, v0y, v1x, v1y, v2x, v2y;
    logic [1:0]    cull;
  } beat_t;

  typedef struct packed {
    logic          ins;
    logic [EW-1:0] w0, w1, w2;
    logic [CW-1:0] px, py;
    logic          lat;
    int            acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vld = 1'b0;
  logic out_ready = 1'b0;
  logic rnd_mode = 1'b0;
  logic [CW-1:0] px = '0, py = '0, v0x = '0, v0y = '0, v1x = '0, v1y = '0, v2x = '0, v2y = '0;
  logic [1:0] cull = '0;

  logic rdy_a, rdy_b, iv_a, iv_b, ov_a, ov_b, ins_a, ins_b;
  logic [EW-1:0] w0_a, w1_a, w2_a, w0_b, w1_b, w2_b;
  logic [CW-1:0] pxo_a, pyo_a, pxo_b, pyo_b;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int seen = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  assign iv_a = vld & rdy_b;
  assign iv_b = vld & rdy_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
  end

  triangle_coverage_pipe #(.COORD_W(CW), .MUL_STAGES(1), .TIE_INCLUSIVE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .inValid(iv_a), .inReady(rdy_a),
    .pixel_x(px), .pixel_y(py), .V0_x(v0x), .V0_y(v0y), .V1_x(v1x), .V1_y(v1y),
    .V2_x(v2x), .V2_y(v2y), .cull_mode(cull), .outValid(ov_a), .outReady(out_ready),
    .isInside(ins_a), .w0(w0_a), .w1(w1_a), .w2(w2_a),
    .pixel_x_out(pxo_a), .pixel_y_out(pyo_a)
  );

  triangle_coverage_pipe #(.COORD_W(CW), .MUL_STAGES(2), .TIE_INCLUSIVE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .inValid(iv_b), .inReady(rdy_b),
    .pixel_x(px), .pixel_y(py), .V0_x(v0x), .V0_y(v0y), .V1_x(v1x), .V1_y(v1y),
    .V2_x(v2x), .V2_y(v2y), .cull_mode(cull), .outValid(ov_b), .outReady(out_ready),
    .isInside(ins_b), .w0(w0_b), .w1(w1_b), .w2(w2_b),
    .pixel_x_out(pxo_b), .pixel_y_out(pyo_b)
  );

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void cmp_beat(input string nm, input exp_t e, input logic ins,
                                   input logic [EW-1:0] a0, a1, a2, input logic [CW-1:0] ax, ay,
                                   input int lat);
    n_chk++;
    if ({ins, a0, a1, a2, ax, ay} !== {e.ins, e.w0, e.w1, e.w2, e.px, e.py}) begin
      n_err++;
      $display("FAIL %s_beat: got ins=%0d w=%0d,%0d,%0d p=(%0d,%0d) want ins=%0d w=%0d,%0d,%0d p=(%0d,%0d)",
               nm, ins, $signed(a0), $signed(a1), $signed(a2), ax, ay,
               e.ins, $signed(e.w0), $signed(e.w1), $signed(e.w2), e.px, e.py);
    end
    if (e.lat) begin
      n_chk++;
      if (cyc - e.acc != lat) begin
        n_err++;
        $display("FAIL %s_latency: got %0d want %0d", nm, cyc - e.acc, lat);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && (ov_a === 1'b1 || ov_b === 1'b1)) seen++;
    if (!reset && ov_a === 1'b1 && out_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL a_unexpected: got beat w0=%0d want none", $signed(w0_a));
      end else begin
        cmp_beat("a", q_a.pop_front(), ins_a, w0_a, w1_a, w2_a, pxo_a, pyo_a, LA);
      end
    end
    if (!reset && ov_b === 1'b1 && out_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL b_unexpected: got beat w0=%0d want none", $signed(w0_b));
      end else begin
        cmp_beat("b", q_b.pop_front(), ins_b, w0_b, w1_b, w2_b, pxo_b, pyo_b, LB);
      end
    end
  end

  function automatic beat_t mk(input int x, y, ax, ay, bx, by, cx, cy, c);
    beat_t b;
    b.px = CW'(x);   b.py = CW'(y);
    b.v0x = CW'(ax); b.v0y = CW'(ay);
    b.v1x = CW'(bx); b.v1y = CW'(by);
    b.v2x = CW'(cx); b.v2y = CW'(cy);
    b.cull = 2'(c);
    return b;
  endfunction

  // Presents one beat and records the expectation on the cycle it is accepted.
  task automatic send(input beat_t b, input longint e0, e1, e2, input logic ia, ib,
                      input logic lat);
    int n;
    exp_t e;
    px = b.px; py = b.py; v0x = b.v0x; v0y = b.v0y;
    v1x = b.v1x; v1y = b.v1y; v2x = b.v2x; v2y = b.v2y; cull = b.cull;
    vld = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy_a && rdy_b) begin
        e.ins = ia; e.w0 = EW'(e0); e.w1 = EW'(e1); e.w2 = EW'(e2);
        e.px = b.px; e.py = b.py; e.lat = lat; e.acc = cyc;
        q_a.push_back(e);
        e.ins = ib;
        q_b.push_back(e);
        @(posedge clk); #1;
        vld = 1'b0;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        n_chk++; n_err++;
        $display("FAIL send_timeout: got no accept in %0d cycles want accept", n);
        vld = 1'b0;
        break;
      end
    end
  endtask

  task automatic dsend(input beat_t b, input longint e0, e1, e2, input logic ia, ib);
    send(b, e0, e1, e2, ia, ib, 1'b0);
  endtask

  function automatic logic classify(input longint w[3], input logic tie, input logic [1:0] c);
    logic pos, neg;
    pos = 1'b1; neg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pos = pos & (tie ? (w[i] >= 0) : (w[i] > 0));
      neg = neg & (tie ? (w[i] <= 0) : (w[i] < 0));
    end
    if (w[0] + w[1] + w[2] == 0) return 1'b0;
    if (c == 2'd0) return pos;
    if (c == 2'd1) return neg;
    return pos | neg;
  endfunction

  task automatic send_model(input beat_t b);
    longint x[3], y[3], w[3], p_x, p_y;
    x[0] = longint'($signed(b.v0x)); y[0] = longint'($signed(b.v0y));
    x[1] = longint'($signed(b.v1x)); y[1] = longint'($signed(b.v1y));
    x[2] = longint'($signed(b.v2x)); y[2] = longint'($signed(b.v2y));
    p_x = longint'(b.px); p_y = longint'(b.py);
    for (int i = 0; i < 3; i++) begin
      w[i] = (p_x - x[(i+1)%3]) * (y[(i+2)%3] - y[(i+1)%3])
           - (p_y - y[(i+1)%3]) * (x[(i+2)%3] - x[(i+1)%3]);
    end
    send(b, w[0], w[1], w[2], classify(w, 1'b1, b.cull), classify(w, 1'b0, b.cull), 1'b0);
  endtask

  function automatic beat_t rnd_beat(input int i);
    beat_t b;
    if (i == 0) return mk(2047, 2047, -1024, -1024, -1024, 1023, 1023, -1024, 2);
    if (i == 1) return mk(0, 0, -1024, -1024, 1023, -1024, -1024, 1023, 0);
    if (i == 2) return mk(2047, 0, -1024, 1023, -1024, -1024, 1023, 1023, 1);
    b = beat_t'({$urandom(), $urandom(), $urandom()});
    return b;
  endfunction

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", 64'(q_a.size() + q_b.size()), 64'd0);
  endtask

  initial begin
    int acc_cnt;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_outvalid_a", 64'(ov_a), 64'd0);
    check("rst_outvalid_b", 64'(ov_b), 64'd0);
    check("rst_inside_a", 64'(ins_a), 64'd0);
    check("rst_w0_a", 64'(w0_a), 64'd0);
    check("rst_pix_a", 64'({pxo_a, pyo_a}), 64'd0);
    check("rst_inready", 64'({rdy_a, rdy_b}), 64'b11);

    // Directed vectors, back to back with outReady high.
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(mk(2, 2, 0, 0, 0, 10, 10, 0, 0), 60, 20, 20, 1'b1, 1'b1, 1'b1);
    dsend(mk(9, 9, 0, 0, 0, 10, 10, 0, 0), -80, 90, 90, 1'b0, 1'b0);
    dsend(mk(0, 5, 0, 0, 0, 10, 10, 0, 0), 50, 50, 0, 1'b1, 1'b0);
    dsend(mk(2, 2, 0, 0, 10, 0, 0, 10, 0), -60, -20, -20, 1'b0, 1'b0);
    dsend(mk(2, 2, 0, 0, 10, 0, 0, 10, 1), -60, -20, -20, 1'b1, 1'b1);
    dsend(mk(2, 2, 0, 0, 10, 0, 0, 10, 2), -60, -20, -20, 1'b1, 1'b1);
    dsend(mk(2, 2, 0, 0, 10, 0, 0, 10, 3), -60, -20, -20, 1'b1, 1'b1);
    dsend(mk(2, 2, 0, 0, 0, 10, 10, 0, 1), 60, 20, 20, 1'b0, 1'b0);
    dsend(mk(0, 5, 0, 0, 0, 10, 10, 0, 2), 50, 50, 0, 1'b1, 1'b0);
    dsend(mk(3, 7, 0, 0, 5, 5, 10, 10, 2), -20, 40, -20, 1'b0, 1'b0);
    dsend(mk(0, 0, 0, 0, 5, 5, 10, 10, 0), 0, 0, 0, 1'b0, 1'b0);
    dsend(mk(2047, 2047, -1024, -1024, -1024, 1023, 1023, -1024, 2),
          -8382465, 6286337, 6286337, 1'b0, 1'b0);
    drain();

    // 20-beat stream under random backpressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 20; i++) send_model(rnd_beat(i));
    rnd_mode = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Fill with the output stalled.
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (!rdy_a) break;
      send_model(rnd_beat(3 + i));
      acc_cnt++;
    end
    check("fill_count", 64'(acc_cnt), 64'(LA));
    check("full_inready_a", 64'(rdy_a), 64'd0);
    check("full_inready_b", 64'(rdy_b), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", 64'({ov_a, ins_a, w0_a, pxo_a}),
            64'({1'b1, q_a[0].ins, q_a[0].w0, q_a[0].px}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    check("ready_rise_a", 64'(rdy_a), 64'd1);
    send_model(rnd_beat(11));
    out_ready = 1'b0;
    #1;
    check("still_full_a", 64'(rdy_a), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset with beats in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_model(rnd_beat(12 + i));
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_outvalid", 64'({ov_a, ov_b}), 64'd0);
    check("midrst_w0_a", 64'(w0_a), 64'd0);
    q_a.delete();
    q_b.delete();
    reset = 1'b0;
    seen = 0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_stale", 64'(seen), 64'd0);
    send(mk(2, 2, 0, 0, 0, 10, 10, 0, 0), 60, 20, 20, 1'b1, 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
